// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures words from the combinational imem into the IF/ID slot.
// Optional macro FETCH_PERF_COUNT_EN enables the saturating accepted-instruction counter on fetch_count.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_valid,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

    state_t      state;
    logic [15:0] pc;
    logic        free;
    logic        handshake;

    assign imem_pc   = pc;
    assign free      = !id_valid || id_ready;
    assign handshake = id_valid && id_ready;

    // Redirect outranks everything and flushes the slot even if decode is taking it this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC_ALIGNED;
            id_instr <= 16'h0000;
            id_pc    <= 16'h0000;
            id_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (redirect) begin
            pc       <= {redirect_pc[15:1], 1'b0};
            id_valid <= 1'b0;
            state    <= RUN;
            halted   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (free) begin
                        id_instr <= imem_instr;
                        id_pc    <= pc;
                        id_valid <= 1'b1;
                        pc       <= pc + PC_STEP;
                    end
                    if (halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (handshake) begin
                        id_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] count_q;

    // Counts every completed handshake, including one coinciding with a redirect flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 16'h0000;
        end else if (handshake && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, randomized run against a transaction-level model,
// a second instance with an odd near-top RESET_PC for alignment and wrap, and counter/async-reset checks.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_valid;
    logic        id_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] imem_pc2;
    logic [15:0] imem_instr2;
    logic [15:0] id_instr2;
    logic [15:0] id_pc2;
    logic        id_valid2;
    logic        halted2;
    logic [15:0] fetch_count2;

    logic [15:0] mem [16];

    int checks = 0;
    int errors = 0;

    // Reference model state: what decode should be seeing and where fetch should be.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_idpc;
    logic        m_valid;
    logic        m_halted;
    int          m_accepted;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [15:0] rpc;
        logic        hlt;
        logic [15:0] exp_imem_pc;
        logic        exp_valid;
        logic [15:0] exp_id_pc;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[19];

    fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .id_ready(id_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted),
        .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(16'hFFFD), .PC_STEP(16'd2)) dut_wrap (
        .clk(clk), .rst(rst), .imem_pc(imem_pc2), .imem_instr(imem_instr2),
        .id_instr(id_instr2), .id_pc(id_pc2), .id_valid(id_valid2), .id_ready(1'b1),
        .redirect(1'b0), .redirect_pc(16'h0000), .halt(1'b0), .halted(halted2),
        .fetch_count(fetch_count2)
    );

    assign imem_instr  = mem[imem_pc[4:1]];
    assign imem_instr2 = mem[imem_pc2[4:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] expected_count();
`ifdef FETCH_PERF_COUNT_EN
        return (m_accepted > 65535) ? 16'hFFFF : 16'(m_accepted);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check16("imem_pc", imem_pc, m_pc);
        check16("id_valid", {15'd0, id_valid}, {15'd0, m_valid});
        check16("id_pc", id_pc, m_idpc);
        check16("id_instr", id_instr, m_instr);
        check16("halted", {15'd0, halted}, {15'd0, m_halted});
        check16("fetch_count", fetch_count, expected_count());
    endtask

    task automatic model_reset();
        m_pc       = 16'h0000;
        m_instr    = 16'h0000;
        m_idpc     = 16'h0000;
        m_valid    = 1'b0;
        m_halted   = 1'b0;
        m_accepted = 0;
    endtask

    // Advance one clock, updating the model from the inputs present just before the edge.
    task automatic tick();
        logic        taken;
        logic [15:0] n_pc, n_instr, n_idpc;
        logic        n_valid, n_halted;
        taken    = m_valid && id_ready;
        n_pc     = m_pc;
        n_instr  = m_instr;
        n_idpc   = m_idpc;
        n_valid  = m_valid;
        n_halted = m_halted;
        if (redirect) begin
            n_pc     = redirect_pc & 16'hFFFE;
            n_valid  = 1'b0;
            n_halted = 1'b0;
        end else if (!m_halted) begin
            if (!m_valid || id_ready) begin
                n_instr = mem[m_pc[4:1]];
                n_idpc  = m_pc;
                n_valid = 1'b1;
                n_pc    = 16'((32'(m_pc) + 2) % 65536);
            end
            if (halt) n_halted = 1'b1;
        end else if (taken) begin
            n_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (taken) m_accepted++;
        m_pc     = n_pc;
        m_instr  = n_instr;
        m_idpc   = n_idpc;
        m_valid  = n_valid;
        m_halted = n_halted;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic r, input logic rd, input logic [15:0] rp, input logic h);
        id_ready    = r;
        redirect    = rd;
        redirect_pc = rp;
        halt        = h;
    endtask

    initial begin
        logic [15:0] wrap_seq [3];
        wrap_seq[0] = 16'hFFFC;
        wrap_seq[1] = 16'hFFFE;
        wrap_seq[2] = 16'h0000;

        for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i * 16'h0111);

        //             ready redir rpc      halt imem_pc  valid id_pc    halted
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0002, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0004, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0004, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0004, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0004, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 16'h0006, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 16'h0006, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h0013, 1'b0, 16'h0012, 1'b0, 16'h0006, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0014, 1'b1, 16'h0012, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0016, 1'b1, 16'h0014, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 16'h0008, 1'b0, 16'h0008, 1'b0, 16'h0014, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b1, 16'h0008, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b1, 16'h0008, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b1, 16'h0008, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b0, 16'h0008, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b0, 16'h0008, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0000, 1'b0};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        checkOutput();
        check16("wrap_reset_pc", imem_pc2, 16'hFFFC);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].ready, vecs[i].redir, vecs[i].rpc, vecs[i].hlt);
            tick();
            check16($sformatf("vec%0d_imem_pc", i), imem_pc, vecs[i].exp_imem_pc);
            check16($sformatf("vec%0d_valid", i), {15'd0, id_valid}, {15'd0, vecs[i].exp_valid});
            check16($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].exp_id_pc);
            check16($sformatf("vec%0d_halted", i), {15'd0, halted}, {15'd0, vecs[i].exp_halted});
            if (vecs[i].exp_valid) check16($sformatf("vec%0d_instr", i), id_instr, mem[vecs[i].exp_id_pc[4:1]]);
            if (i < 3) check16($sformatf("wrap_id_pc%0d", i), id_pc2, wrap_seq[i]);
        end

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                          16'($urandom), ($urandom_range(0, 19) == 0));
            tick();
        end

        // Counter run: 11 edges with decode always ready yields 10 accepted instructions.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 11; i++) tick();
`ifdef FETCH_PERF_COUNT_EN
        check16("count_after_10", fetch_count, 16'd10);
`else
        check16("count_tied_zero", fetch_count, 16'd0);
`endif

        // Asynchronous reset mid-cycle must clear everything before the next edge.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check16("async_count", fetch_count, 16'h0000);
        check16("async_valid", {15'd0, id_valid}, 16'h0000);
        check16("async_pc", imem_pc, 16'h0000);
        check16("async_wrap_pc", imem_pc2, 16'hFFFC);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
